eth_tx_framer: RTL



---
 rtl/eth_tx_pkg.sv | 27 ++
 rtl/eth_tx_framer_if.sv | 29 ++
 rtl/crc32_byte.sv | 24 ++
 rtl/eth_tx_framer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet transmit framer.
// Contents:
//   state_t       - framer FSM states
//   PREAMBLE_BYTE - preamble octet (sent PREAMBLE_LEN times)
//   SFD_BYTE      - start-of-frame delimiter
//   CRC32_POLY    - reflected IEEE 802.3 CRC-32 polynomial
//   CRC32_INIT    - CRC register value at the start of every frame
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        DRAIN,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Byte-wide AXI-Stream link from the TX FIFO / packet builder into the framer.
// Signals:
//   s_axis_tdata  - payload byte
//   s_axis_tvalid - byte valid
//   s_axis_tlast  - last byte of frame
//   s_axis_tuser  - error/abort marker on the accepted byte
//   s_axis_trdy   - sink ready
// Handshake: a byte transfers on the rising clock edge where tvalid and trdy
// are both high. trdy is driven from a flop and never depends on tvalid in
// the same cycle.
interface eth_tx_framer_if #(
    parameter int W = 8
);
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tuser;
    logic         s_axis_trdy;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_trdy
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_trdy
    );
endinterface

// File: rtl/crc32_byte.sv
// One-byte step of the reflected CRC-32 (poly 0xEDB88320). Purely
// combinational; the caller owns the CRC register.
// Ports:
//   crc_i  - current CRC state
//   data_i - byte to fold in (LSB first on the wire)
//   crc_o  - CRC state after data_i
module crc32_byte
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h000000, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet MAC transmit framer: AXI-Stream bytes in, GMII-style bytes out.
// Adds 7x preamble + SFD, zero-pads short frames, appends the CRC-32 FCS and
// holds off the next frame for IFG_CYCLES idle cycles.
// Ports:
//   s_aclk, s_sresetn - clock, asynchronous active-low reset
//   s_axis            - byte stream in (slave side)
//   m_tx_data/en/er   - registered byte, frame enable and error strobe to PHY
//   o_frame_done      - one-cycle pulse with the last FCS byte of a good frame
//   o_frame_err       - one-cycle pulse with the error strobe of an aborted frame
//   dbg_state         - current FSM state
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MIN_PAYLOAD    = 60,
    parameter int IFG_CYCLES     = 12
) (
    input  logic                  s_aclk,
    input  logic                  s_sresetn,
    eth_tx_framer_if.slave        s_axis,
    output logic [7:0]            m_tx_data,
    output logic                  m_tx_en,
    output logic                  m_tx_er,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output state_t                dbg_state
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

    // Reset asserts asynchronously through the clear of these flops and
    // deasserts two edges after s_sresetn rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge s_aclk or negedge s_sresetn) begin
        if (!s_sresetn) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;     // payload + pad bytes, saturating
    logic [7:0]  aux_q, aux_d;     // preamble / FCS byte / IFG cycle index
    logic [31:0] crc_q, crc_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        trdy_q, trdy_d;

    logic [AXI_DATA_WIDTH-1:0] byte_in;
    logic [7:0]                crc_byte;
    logic [31:0]               crc_next;
    logic [31:0]               fcs;
    logic [10:0]               cnt_inc;

    assign byte_in  = s_axis.s_axis_tdata;
    assign crc_byte = (state_q == PAD) ? 8'h00 : byte_in;
    assign fcs      = ~crc_q;
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aux_d   = aux_q;
        crc_d   = crc_q;
        data_d  = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_axis.s_axis_tvalid) begin
                    state_d = PREAMBLE;
                    data_d  = PREAMBLE_BYTE;
                    en_d    = 1'b1;
                    aux_d   = 8'd1;
                    cnt_d   = 11'd0;
                    crc_d   = CRC32_INIT;
                end
            end
            PREAMBLE: begin
                data_d = PREAMBLE_BYTE;
                en_d   = 1'b1;
                aux_d  = aux_q + 8'd1;
                if (aux_q == PRE_LAST) state_d = SFD;
            end
            SFD: begin
                data_d  = SFD_BYTE;
                en_d    = 1'b1;
                state_d = PAYLOAD;
            end
            PAYLOAD: begin
                en_d = 1'b1;
                aux_d = 8'd0;
                if (!s_axis.s_axis_tvalid) begin
                    // Upstream underflow: the frame cannot be completed.
                    er_d    = 1'b1;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    data_d = byte_in;
                    cnt_d  = cnt_inc;
                    crc_d  = crc_next;
                    if (s_axis.s_axis_tuser) begin
                        er_d    = 1'b1;
                        err_d   = 1'b1;
                        state_d = s_axis.s_axis_tlast ? IFG : DRAIN;
                    end else if (s_axis.s_axis_tlast) begin
                        state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                en_d  = 1'b1;
                cnt_d = cnt_inc;
                crc_d = crc_next;
                aux_d = 8'd0;
                if (cnt_inc == MIN_CNT) state_d = FCS;
            end
            FCS: begin
                en_d  = 1'b1;
                aux_d = aux_q + 8'd1;
                case (aux_q[1:0])
                    2'd0:    data_d = fcs[7:0];
                    2'd1:    data_d = fcs[15:8];
                    2'd2:    data_d = fcs[23:16];
                    default: data_d = fcs[31:24];
                endcase
                if (aux_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    aux_d   = 8'd0;
                    state_d = IFG;
                end
            end
            DRAIN: begin
                aux_d = 8'd0;
                if (s_axis.s_axis_tvalid && s_axis.s_axis_tlast) state_d = IFG;
            end
            IFG: begin
                // Counts cycles with m_tx_en low; IDLE may start the next
                // preamble on the edge after the last gap cycle.
                if (aux_q == IFG_LAST) state_d = IDLE;
                else                   aux_d   = aux_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        trdy_d = (state_d == PAYLOAD) || (state_d == DRAIN);
    end

    always_ff @(posedge s_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 11'd0;
            aux_q   <= 8'd0;
            crc_q   <= CRC32_INIT;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            trdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aux_q   <= aux_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            en_q    <= en_d;
            er_q    <= er_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trdy_q  <= trdy_d;
        end
    end

    assign s_axis.s_axis_trdy = trdy_q;
    assign m_tx_data          = data_q;
    assign m_tx_en            = en_q;
    assign m_tx_er            = er_q;
    assign o_frame_done       = done_q;
    assign o_frame_err        = err_q;
    assign dbg_state          = state_q;

endmodule
